// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter slice.
// Opcodes match the encoding requesters drive on req_op.
package alu_arbiter_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SHL = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHR = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_AND = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit ALU shared by all arbiter requesters.
// Unsigned wrap-around arithmetic; shifts by 32 or more yield zero.
module alu
  import alu_arbiter_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output logic [31:0] out,
  output logic        zero_f,
  output logic        sign_f
);

  logic big;

  assign big = |b[31:5];

  always_comb begin
    out = '0;
    unique case (1'b1)
      (op == OP_ADD): out = a + b;
      (op == OP_SUB): out = a - b;
      (op == OP_SHL): out = big ? '0 : a << b[4:0];
      (op == OP_SHR): out = big ? '0 : a >> b[4:0];
      (op == OP_XOR): out = a ^ b;
      (op == OP_OR):  out = a | b;
      (op == OP_AND): out = a & b;
      default:        out = '0;
    endcase
  end

  assign zero_f = (out == '0);
  assign sign_f = out[31];

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU among NREQ requesters,
// one operation in flight, results returned over valid/ready.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter  int NREQ = 2,
  localparam int GW   = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  input  logic [NREQ*3-1:0] req_op,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [31:0]       rsp_out,
  output logic              rsp_zero,
  output logic              rsp_sign,
  output logic              busy,
  output logic [GW-1:0]     grant_id
);

  state_t      state;
  logic [GW-1:0] last;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [2:0]  op_q;

  logic        found;
  logic [GW-1:0] winner;
  logic [31:0] alu_out;
  logic        alu_zero;
  logic        alu_sign;

  // Scan starts just after the last grant so every requester gets a turn.
  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = GW'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && found)
      req_ready[winner] = 1'b1;
  end

  always_comb begin
    rsp_valid = '0;
    if (state == S_RESP)
      rsp_valid[grant_id] = 1'b1;
  end

  assign busy = (state != S_IDLE);

  alu u_alu (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .out    (alu_out),
    .zero_f (alu_zero),
    .sign_f (alu_sign)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      last     <= GW'(NREQ - 1);
      grant_id <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      rsp_out  <= '0;
      rsp_zero <= 1'b0;
      rsp_sign <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (found) begin
            a_q      <= req_a[int'(winner)*32 +: 32];
            b_q      <= req_b[int'(winner)*32 +: 32];
            op_q     <= req_op[int'(winner)*3 +: 3];
            grant_id <= winner;
            last     <= winner;
            state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          rsp_out  <= alu_out;
          rsp_zero <= alu_zero;
          rsp_sign <= alu_sign;
          state    <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready[grant_id])
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with two requesters.
// Stimulus changes on falling edges; outputs sampled 1ns later.
module tb_alu_arbiter;

  localparam int N = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*32-1:0]  req_a;
  logic [N*32-1:0]  req_b;
  logic [N*3-1:0]   req_op;
  logic [N-1:0]     rsp_valid;
  logic [N-1:0]     rsp_ready;
  logic [31:0]      rsp_out;
  logic             rsp_zero;
  logic             rsp_sign;
  logic             busy;
  logic [0:0]       grant_id;

  typedef struct {
    int          id;
    logic [31:0] out;
    logic        z;
    logic        s;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  alu_arbiter #(.NREQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_out   (rsp_out),
    .rsp_zero  (rsp_zero),
    .rsp_sign  (rsp_sign),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic [2:0]  op);
    logic [31:0] r;
    case (op)
      3'b000:  r = a + b;
      3'b001:  r = (b >= 32) ? 32'd0 : a << b;
      3'b010:  r = a - b;
      3'b100:  r = a ^ b;
      3'b101:  r = (b >= 32) ? 32'd0 : a >> b;
      3'b110:  r = a | b;
      3'b111:  r = a & b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  task automatic set_req(input int id, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] op);
    req_a[32*id +: 32] = a;
    req_b[32*id +: 32] = b;
    req_op[3*id +: 3]  = op;
  endtask

  task automatic push_exp(input int id);
    exp_t r;
    r.id  = id;
    r.out = model(req_a[32*id +: 32], req_b[32*id +: 32], req_op[3*id +: 3]);
    r.z   = (r.out == 32'd0);
    r.s   = r.out[31];
    sb.push_back(r);
  endtask

  function automatic exp_t pop_exp();
    exp_t r;
    r.id = -1; r.out = 32'hx; r.z = 1'bx; r.s = 1'bx;
    if (sb.size() != 0) r = sb.pop_front();
    return r;
  endfunction

  // Drives one request and collects its response; checks are done by callers.
  task automatic run_op(input int id, input logic [31:0] a,
                        input logic [31:0] b, input logic [2:0] op,
                        output int lat, output int rid,
                        output logic [31:0] o, output logic z,
                        output logic s);
    int w;
    set_req(id, a, b, op);
    req_valid[id] = 1'b1;
    w = 0; lat = -1; rid = -1; o = 32'hx; z = 1'bx; s = 1'bx;
    #1;
    while (!req_ready[id] && w < 20) begin
      @(negedge clk); #1; w++;
    end
    if (!req_ready[id]) begin
      req_valid[id] = 1'b0;
      @(negedge clk);
      return;
    end
    push_exp(id);
    @(negedge clk);
    req_valid[id] = 1'b0;
    lat = 1;
    #1;
    while (rsp_valid == '0 && lat < 20) begin
      @(negedge clk); #1; lat++;
    end
    if (rsp_valid != '0) begin
      rid = rsp_valid[1] ? 1 : 0;
      o = rsp_out; z = rsp_zero; s = rsp_sign;
    end else begin
      lat = -1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = '0; rsp_ready = '1;
    req_a = '0; req_b = '0; req_op = '0;
    @(negedge clk); @(negedge clk); #1;
    checks++;
    if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got ready=%b valid=%b busy=%b want 00 00 0",
               req_ready, rsp_valid, busy);
    end
    checks++;
    if (rsp_out !== 32'd0 || rsp_zero !== 1'b0 || rsp_sign !== 1'b0) begin
      errors++;
      $display("FAIL reset_rsp got out=%h z=%b s=%b want 0 0 0",
               rsp_out, rsp_zero, rsp_sign);
    end
    checks++;
    if (grant_id !== 1'b0) begin
      errors++;
      $display("FAIL reset_grant got %b want 0", grant_id);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_add();
    int lat, rid; logic [31:0] o; logic z, s; exp_t e;
    run_op(0, 32'd5, 32'd7, 3'b000, lat, rid, o, z, s);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL add_latency got %0d want 2", lat);
    end
    e = pop_exp();
    checks++;
    if (rid !== e.id || o !== e.out || z !== e.z || s !== e.s) begin
      errors++;
      $display("FAIL add_sb got id=%0d out=%h z=%b s=%b want id=%0d out=%h z=%b s=%b",
               rid, o, z, s, e.id, e.out, e.z, e.s);
    end
    checks++;
    if (o !== 32'd12 || z !== 1'b0 || s !== 1'b0) begin
      errors++;
      $display("FAIL add_value got out=%h z=%b s=%b want 0000000c 0 0", o, z, s);
    end
  endtask

  task automatic test_sub_and_nop();
    int lat, rid; logic [31:0] o; logic z, s; exp_t e;
    run_op(0, 32'd3, 32'd5, 3'b010, lat, rid, o, z, s);
    e = pop_exp();
    checks++;
    if (lat !== 2 || rid !== e.id || o !== e.out || z !== e.z || s !== e.s) begin
      errors++;
      $display("FAIL sub_sb got lat=%0d out=%h z=%b s=%b want 2 %h %b %b",
               lat, o, z, s, e.out, e.z, e.s);
    end
    checks++;
    if (o !== 32'hFFFF_FFFE || s !== 1'b1) begin
      errors++;
      $display("FAIL sub_value got out=%h s=%b want fffffffe 1", o, s);
    end
    run_op(0, 32'd3, 32'd5, 3'b011, lat, rid, o, z, s);
    e = pop_exp();
    checks++;
    if (lat !== 2 || o !== 32'd0 || z !== 1'b1 || s !== 1'b0 || o !== e.out) begin
      errors++;
      $display("FAIL op011 got lat=%0d out=%h z=%b s=%b want 2 0 1 0",
               lat, o, z, s);
    end
  endtask

  task automatic test_shift_edge();
    int lat, rid; logic [31:0] o; logic z, s; exp_t e;
    run_op(1, 32'd1, 32'd31, 3'b001, lat, rid, o, z, s);
    e = pop_exp();
    checks++;
    if (lat !== 2 || rid !== 1 || o !== 32'h8000_0000 || s !== 1'b1 || o !== e.out) begin
      errors++;
      $display("FAIL shl31 got lat=%0d id=%0d out=%h s=%b want 2 1 80000000 1",
               lat, rid, o, s);
    end
    run_op(1, 32'd1, 32'd32, 3'b001, lat, rid, o, z, s);
    e = pop_exp();
    checks++;
    if (lat !== 2 || o !== 32'd0 || z !== 1'b1 || o !== e.out) begin
      errors++;
      $display("FAIL shl32 got lat=%0d out=%h z=%b want 2 0 1", lat, o, z);
    end
  endtask

  task automatic test_ops();
    logic [2:0] ops [8];
    int lat, rid; logic [31:0] o, a, b; logic z, s; exp_t e;
    ops = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      b = (i % 4 == 3) ? $urandom : 32'($urandom_range(0, 40));
      run_op(i % 2, a, b, ops[i % 8], lat, rid, o, z, s);
      e = pop_exp();
      checks++;
      if (lat !== 2 || rid !== e.id || o !== e.out || z !== e.z || s !== e.s) begin
        errors++;
        $display("FAIL ops_%0d got lat=%0d id=%0d out=%h z=%b s=%b want 2 %0d %h %b %b",
                 i, lat, rid, o, z, s, e.id, e.out, e.z, e.s);
      end
    end
  endtask

  task automatic test_contention();
    int grants, cyc, idx, rid; exp_t e;
    rst_n = 1'b0; req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    set_req(0, 32'd1, 32'd1, 3'b000);
    set_req(1, 32'h0000_00F0, 32'h0000_000F, 3'b110);
    req_valid = 2'b11;
    grants = 0; cyc = 0;
    while ((grants < 4 || sb.size() != 0) && cyc < 80) begin
      if (grants == 4) req_valid = '0;
      #1;
      if (req_ready != '0) begin
        idx = req_ready[1] ? 1 : 0;
        checks++;
        if (!$onehot(req_ready) || idx !== grants % 2) begin
          errors++;
          $display("FAIL rr_grant_%0d got ready=%b want id %0d", grants, req_ready, grants % 2);
        end
        push_exp(idx);
        grants++;
      end
      if (rsp_valid != '0) begin
        rid = rsp_valid[1] ? 1 : 0;
        e = pop_exp();
        checks++;
        if (!$onehot(rsp_valid) || rid !== e.id || rsp_out !== e.out ||
            rsp_zero !== e.z || rsp_sign !== e.s) begin
          errors++;
          $display("FAIL rr_rsp got valid=%b out=%h want id=%0d out=%h",
                   rsp_valid, rsp_out, e.id, e.out);
        end
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (grants != 4 || sb.size() != 0) begin
      errors++;
      $display("FAIL rr_timeout got grants=%0d pending=%0d want 4 0", grants, sb.size());
    end
  endtask

  task automatic test_back_pressure();
    int w, lat; logic [31:0] held; exp_t e;
    rsp_ready = '0;
    set_req(0, 32'h1234_5678, 32'h0F0F_0F0F, 3'b100);
    req_valid = 2'b01;
    w = 0; #1;
    while (!req_ready[0] && w < 20) begin @(negedge clk); #1; w++; end
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL bp_accept got ready=%b want 01", req_ready);
    end
    push_exp(0);
    @(negedge clk);
    set_req(1, 32'h0000_00F0, 32'h0000_000F, 3'b110);
    req_valid = 2'b10;
    lat = 1; #1;
    while (!rsp_valid[0] && lat < 20) begin @(negedge clk); #1; lat++; end
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL bp_latency got %0d want 2", lat);
    end
    held = rsp_out;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      checks++;
      if (rsp_valid !== 2'b01 || rsp_out !== held || req_ready !== 2'b00) begin
        errors++;
        $display("FAIL bp_hold_%0d got valid=%b out=%h ready=%b want 01 %h 00",
                 i, rsp_valid, rsp_out, req_ready, held);
      end
    end
    @(negedge clk);
    rsp_ready = 2'b10;
    #1;
    checks++;
    if (rsp_valid !== 2'b01 || req_ready !== 2'b00) begin
      errors++;
      $display("FAIL bp_wrong_ready got valid=%b ready=%b want 01 00", rsp_valid, req_ready);
    end
    @(negedge clk);
    rsp_ready = 2'b11;
    #1;
    e = pop_exp();
    checks++;
    if (rsp_valid !== 2'b01 || rsp_out !== e.out || rsp_zero !== e.z || rsp_sign !== e.s) begin
      errors++;
      $display("FAIL bp_result got valid=%b out=%h want 01 %h", rsp_valid, rsp_out, e.out);
    end
    @(negedge clk); #1;
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("FAIL bp_next_grant got ready=%b want 10", req_ready);
    end
    push_exp(1);
    @(negedge clk);
    req_valid = '0;
    lat = 1; #1;
    while (!rsp_valid[1] && lat < 20) begin @(negedge clk); #1; lat++; end
    e = pop_exp();
    checks++;
    if (lat !== 2 || rsp_out !== e.out || rsp_out !== 32'h0000_00FF) begin
      errors++;
      $display("FAIL bp_second got lat=%0d out=%h want 2 %h", lat, rsp_out, e.out);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_exec();
    int w, lat; exp_t e;
    set_req(1, 32'h0000_0F00, 32'h0000_0100, 3'b010);
    req_valid = 2'b10;
    w = 0; #1;
    while (!req_ready[1] && w < 20) begin @(negedge clk); #1; w++; end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++;
    if (busy !== 1'b1 || grant_id !== 1'b1) begin
      errors++;
      $display("FAIL mid_exec got busy=%b grant=%b want 1 1", busy, grant_id);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 2'b00 || busy !== 1'b0 || grant_id !== 1'b0 ||
        rsp_out !== 32'd0 || rsp_zero !== 1'b0 || rsp_sign !== 1'b0 ||
        req_ready !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset got valid=%b busy=%b grant=%b out=%h z=%b s=%b ready=%b want all 0",
               rsp_valid, busy, grant_id, rsp_out, rsp_zero, rsp_sign, req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      checks++;
      if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
        errors++;
        $display("FAIL stale_rsp_%0d got valid=%b busy=%b want 00 0", i, rsp_valid, busy);
      end
    end
    @(negedge clk);
    set_req(0, 32'd40, 32'd2, 3'b000);
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL post_reset_grant got ready=%b want 01", req_ready);
    end
    push_exp(0);
    @(negedge clk);
    req_valid = '0;
    lat = 1; #1;
    while (rsp_valid == '0 && lat < 20) begin @(negedge clk); #1; lat++; end
    e = pop_exp();
    checks++;
    if (lat !== 2 || rsp_valid !== 2'b01 || rsp_out !== e.out) begin
      errors++;
      $display("FAIL post_reset_rsp got lat=%0d valid=%b out=%h want 2 01 %h",
               lat, rsp_valid, rsp_out, e.out);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_add();
    test_sub_and_nop();
    test_shift_edge();
    test_ops();
    test_contention();
    test_back_pressure();
    test_reset_mid_exec();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
